uart_tx_baud: RTL and testbench

Serial UART transmitter that consumes the divided baud clock produced by the baud-rate divider and shifts out one LSB-first frame per request: start bit, data bits, optional parity bit, stop bits. Runs entirely in the `clock_in` domain. `baud_clk` is sampled as an ordinary synchronous signal, and each rising edge of it is one bit-period strobe. Sits between the byte source (controller/FIFO) and the board TX pin.

---
 rtl/uart_tx_baud.sv | 119 +++++++++++
 tb/tb_uart_tx_baud.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_baud.sv
// uart_tx_baud: LSB-first UART transmitter advanced by rising edges of baud_clk (clock_in domain).
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_baud #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock_in,
  input  logic                 rst,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_line
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t               state;
  logic                 baud_prev;
  logic                 tick;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_cnt;
  logic                 stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign tick = baud_clk & ~baud_prev;

  always_ff @(posedge clock_in) begin
    if (rst) begin
      state      <= IDLE;
      baud_prev  <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      tx_line    <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      baud_prev <= baud_clk;
      tx_done   <= 1'b0;
      unique case (state)
        // A tick coinciding with acceptance is dropped: WAIT only sees later ticks.
        IDLE: begin
          tx_line <= 1'b1;
          if (tx_start) begin
            shift   <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
            tx_busy <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: if (tick) begin
          tx_line <= 1'b0;
          state   <= START;
        end
        START: if (tick) begin
          tx_line <= shift[0];
          shift   <= shift >> 1;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: if (tick) begin
          if (bit_cnt != LAST_BIT) begin
            tx_line <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_line <= parity_bit;
            state   <= PARITY;
`else
            tx_line  <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          tx_line  <= 1'b1;
          stop_cnt <= 1'b0;
          state    <= STOP;
        end
`endif
        STOP: if (tick) begin
          if (stop_cnt != LAST_STOP) begin
            stop_cnt <= stop_cnt + 1'b1;
          end else begin
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_baud.sv
// Directed bench for uart_tx_baud: one-stop and two-stop instances, baud_clk toggling every 4 cycles.
module tb_uart_tx_baud;

  logic       clock_in = 1'b0;
  logic       rst;
  logic       baud_clk;
  logic [7:0] data1, data2;
  logic       start1, start2;
  logic       busy1, done1, line1;
  logic       busy2, done2, line2;
  logic       prev_b;
  int         errors = 0;
  int         checks = 0;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  uart_tx_baud #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clock_in(clock_in), .rst(rst), .baud_clk(baud_clk),
    .tx_data(data1), .tx_start(start1),
    .tx_busy(busy1), .tx_done(done1), .tx_line(line1)
  );

  uart_tx_baud #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clock_in(clock_in), .rst(rst), .baud_clk(baud_clk),
    .tx_data(data2), .tx_start(start2),
    .tx_busy(busy2), .tx_done(done2), .tx_line(line2)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    baud_clk = 1'b0;
    forever begin
      repeat (4) @(posedge clock_in);
      #1 baud_clk = ~baud_clk;
    end
  end

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 2) ? line2 : line1;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 2) ? busy2 : busy1;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 2) ? done2 : done1;
  endfunction

  // Returns at the negedge where baud_clk is first seen high after being low.
  task automatic wait_rise();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (baud_clk && !prev_b) found = 1'b1;
      prev_b = baud_clk;
      if (!found) @(negedge clock_in);
    end
    check("tick_wait", found, 1'b1);
  endtask

  task automatic start_req(input int sel, input logic [7:0] d);
    prev_b = baud_clk;
    if (sel == 2) begin data2 = d; start2 = 1'b1; end
    else          begin data1 = d; start1 = 1'b1; end
    @(negedge clock_in);
    start1 = 1'b0;
    start2 = 1'b0;
    data1  = ~d;
    data2  = ~d;
    check("busy_after_accept", busy_of(sel), 1'b1);
  endtask

  task automatic check_frame(input int sel, input logic [7:0] d, input logic exp_par,
                             input int glitch_at, input int abort_at);
    int         nstop;
    int         n;
    logic [15:0] seq;
    nstop = (sel == 2) ? 2 : 1;
    n     = 1 + 8 + PAR + nstop;
    seq   = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1+i] = d[i];
    if (PAR == 1) seq[9] = exp_par;
    for (int k = 0; k < n; k++) begin
      wait_rise();
      @(negedge clock_in);
      check($sformatf("line_bit%0d_%02h", k, d), line_of(sel), seq[k]);
      check("busy_in_frame", busy_of(sel), 1'b1);
      if (k == glitch_at) begin
        if (sel == 2) begin data2 = 8'h00; start2 = 1'b1; end
        else          begin data1 = 8'h00; start1 = 1'b1; end
        @(negedge clock_in);
        start1 = 1'b0;
        start2 = 1'b0;
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clock_in);
        rst = 1'b0;
        check("line_after_rst", line_of(sel), 1'b1);
        check("busy_after_rst", busy_of(sel), 1'b0);
        check("done_after_rst", done_of(sel), 1'b0);
        return;
      end
    end
    wait_rise();
    @(negedge clock_in);
    check($sformatf("done_pulse_%02h", d), done_of(sel), 1'b1);
    check("busy_end", busy_of(sel), 1'b0);
    check("line_end", line_of(sel), 1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    data1  = '0;
    data2  = '0;
    prev_b = 1'b0;
    repeat (3) @(negedge clock_in);
    check("rst_line", line1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_line2", line2, 1'b1);
    check("rst_busy2", busy2, 1'b0);
    rst = 1'b0;
    @(negedge clock_in);

    start_req(1, 8'h55);
    check_frame(1, 8'h55, 1'b0, -1, -1);
    @(negedge clock_in);
    check("done_single_55", done1, 1'b0);

    start_req(1, 8'hA5);
    check_frame(1, 8'hA5, 1'b0, -1, -1);
    @(negedge clock_in);

    start_req(1, 8'h07);
    check_frame(1, 8'h07, 1'b1, -1, -1);
    // New request in the tx_done cycle: accepted, start bit on the next tick.
    start_req(1, 8'h96);
    check_frame(1, 8'h96, 1'b0, -1, -1);
    @(negedge clock_in);
    check("done_single_96", done1, 1'b0);

    start_req(2, 8'hFF);
    check_frame(2, 8'hFF, 1'b0, -1, -1);
    @(negedge clock_in);
    check("done_single_ff", done2, 1'b0);

    start_req(1, 8'h3C);
    check_frame(1, 8'h3C, 1'b0, 3, -1);
    for (int t = 0; t < 3; t++) begin
      wait_rise();
      @(negedge clock_in);
      check("no_second_busy", busy1, 1'b0);
      check("no_second_line", line1, 1'b1);
      check("no_second_done", done1, 1'b0);
    end

    start_req(1, 8'h81);
    check_frame(1, 8'h81, 1'b0, -1, 4);
    @(negedge clock_in);
    start_req(1, 8'h81);
    check_frame(1, 8'h81, 1'b0, -1, -1);
    @(negedge clock_in);
    check("done_single_81", done1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
